i2s_capture_ctrl: RTL

//  Capture sequencer for the EF_I2S receiver. It flushes the receiver FIFO and enables the I2S clocks.

---
 rtl/i2s_ctrl_pkg.sv | 6 +
 rtl/i2s_ctrl_outbuf.sv | 30 +++
 rtl/i2s_capture_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/i2s_ctrl_pkg.sv
// i2s_ctrl_pkg: shared state type and constants for the I2S capture controller
package i2s_ctrl_pkg;
  localparam int DEF_DW = 32;
  localparam int ADDR_STRIDE = DEF_DW / 8;
  typedef enum logic [2:0] {IDLE, FLUSH, ARM, CAPTURE, FINISH, ABORT} state_t;
endpackage

// File: rtl/i2s_ctrl_outbuf.sv
// i2s_ctrl_outbuf: one-entry valid/ready register driving the memory write port
module i2s_ctrl_outbuf #(
  parameter int DW = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DW-1:0]     m_data,
  output logic              can_load
);
  assign can_load = !m_valid || m_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
    end else if (ld) begin
      m_valid <= 1'b1;
      m_addr  <= ld_addr;
      m_data  <= ld_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
endmodule

// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl: flushes/enables EF_I2S, optionally waits for VAD, streams FIFO words to memory
module i2s_capture_ctrl
  import i2s_ctrl_pkg::*;
#(
  parameter int DW = 8 * ADDR_STRIDE,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 16,
  parameter int TO_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              vad_mode,
  input  logic [LEN_W-1:0]  capture_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [TO_W-1:0]   arm_timeout,
  input  logic              vad_flag,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [DW-1:0]     fifo_rdata,
  output logic              i2s_en,
  output logic              fifo_en,
  output logic              fifo_flush,
  output logic              fifo_rd,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DW-1:0]     m_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              timed_out,
  output logic              overrun
);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DW / 8);
  state_t state;
  logic [LEN_W-1:0] words_left;
  logic [ADDR_W-1:0] next_addr;
  logic [TO_W-1:0] to_lim, to_cnt;
  logic can_load, ld;
  // the pop must coincide with sampling the head word to sustain 1 word/cycle
  assign ld = state == CAPTURE && !stop && can_load && !fifo_empty && words_left != '0;
  assign fifo_rd = ld;
  i2s_ctrl_outbuf #(.DW(DW), .ADDR_W(ADDR_W)) u_outbuf (
    .clk(clk), .rst(rst), .ld(ld), .ld_addr(next_addr), .ld_data(fifo_rdata),
    .m_ready(m_ready), .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .can_load(can_load)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      words_left <= '0;
      next_addr  <= '0;
      to_lim     <= '0;
      to_cnt     <= '0;
      i2s_en     <= 1'b0;
      fifo_en    <= 1'b0;
      fifo_flush <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      timed_out  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done       <= 1'b0;
      aborted    <= 1'b0;
      fifo_flush <= 1'b0;
      if (ld) begin
        next_addr  <= next_addr + STRIDE;
        words_left <= words_left - LEN_W'(1);
      end
      if (state == CAPTURE && fifo_full) overrun <= 1'b1;
      if (stop && state != IDLE && state != ABORT) begin
        state      <= ABORT;
        i2s_en     <= 1'b0;
        fifo_en    <= 1'b0;
        fifo_flush <= 1'b1;
      end else begin
        case (state)
          IDLE:
            if (start && !stop) begin
              words_left <= capture_len;
              next_addr  <= base_addr;
              to_lim     <= arm_timeout;
              to_cnt     <= '0;
              timed_out  <= 1'b0;
              overrun    <= 1'b0;
              done       <= capture_len == '0;
              if (capture_len != '0) begin
                state      <= FLUSH;
                fifo_flush <= 1'b1;
                busy       <= 1'b1;
              end
            end
          FLUSH: begin
            state  <= ARM;
            i2s_en <= 1'b1;
          end
          ARM:
            if (!vad_mode || vad_flag) begin
              state   <= CAPTURE;
              fifo_en <= 1'b1;
            end else if (to_lim != '0 && to_cnt == to_lim - TO_W'(1)) begin
              state      <= ABORT;
              timed_out  <= 1'b1;
              i2s_en     <= 1'b0;
              fifo_flush <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          CAPTURE:
            if (ld && words_left == LEN_W'(1)) begin
              state   <= FINISH;
              i2s_en  <= 1'b0;
              fifo_en <= 1'b0;
            end
          FINISH, ABORT:
            if (can_load) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= state == FINISH;
              aborted <= state == ABORT;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule
